// File: rtl/mmcm_drp_reconfig.sv
// MMCM DRP reconfiguration master: holds the MMCM in reset, read-modify-writes
// the DRP table entries of the selected configuration, then waits for lock.
module mmcm_drp_reconfig #(
    parameter int N_REGS       = 23,
    parameter int N_CFG        = 2,
    parameter int CFG_W        = 1,
    parameter int RST_HOLD     = 4,
    parameter int DRP_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535,
    localparam int AW = (N_CFG * N_REGS > 1) ? $clog2(N_CFG * N_REGS) : 1
) (
    input  logic             clk12,
    input  logic             rst,
    input  logic             start,
    input  logic [CFG_W-1:0] cfg_sel,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    rom_addr,
    input  logic [38:0]      rom_data,
    output logic [6:0]       daddr,
    output logic [15:0]      di,
    output logic             den,
    output logic             dwe,
    input  logic [15:0]      drp_do,
    input  logic             drdy,
    output logic             mmcm_rst,
    input  logic             locked
);

    localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int M1 = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
    localparam int M2 = (M1 > RST_HOLD) ? M1 : RST_HOLD;
    localparam int CW = $clog2(M2 + 1);

    typedef enum logic [3:0] {
        IDLE, HOLD, FETCH, LATCH, READ,
        WAIT_RD, WRITE, WAIT_WR, RELEASE, WAIT_LOCK
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [31:0]      ent_q, ent_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             busy_q, busy_d;
    logic             mrst_q, mrst_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             lock_s1_q, lock_s2_q;

    function automatic logic [AW-1:0] tbl_addr(
        input logic [CFG_W-1:0] c,
        input logic [IW-1:0]    i
    );
        return AW'(int'(c) * N_REGS + int'(i));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cfg_d   = cfg_q;
        ent_d   = ent_q;
        addr_d  = addr_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        busy_d  = busy_q;
        mrst_d  = mrst_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d   = cfg_sel;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    mrst_d  = 1'b1;
                    idx_d   = '0;
                    cnt_d   = CW'(RST_HOLD - 1);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    addr_d  = tbl_addr(cfg_q, idx_q);
                    state_d = FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                ent_d   = rom_data[31:0];
                daddr_d = rom_data[38:32];
                state_d = READ;
            end
            READ: begin
                cnt_d   = CW'(DRP_TIMEOUT - 1);
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                // drdy on the expiry cycle still wins over the timeout
                if (drdy) begin
                    di_d    = (drp_do & ent_q[31:16]) |
                              (ent_q[15:0] & ~ent_q[31:16]);
                    state_d = WRITE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    mrst_d  = 1'b0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                cnt_d   = CW'(DRP_TIMEOUT - 1);
                state_d = WAIT_WR;
            end
            WAIT_WR: begin
                if (drdy) begin
                    if (idx_q == IW'(N_REGS - 1)) begin
                        mrst_d  = 1'b0;
                        state_d = RELEASE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        addr_d  = tbl_addr(cfg_q, idx_q + 1'b1);
                        state_d = FETCH;
                    end
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    mrst_d  = 1'b0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                cnt_d   = CW'(LOCK_TIMEOUT - 1);
                state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            cfg_q     <= '0;
            ent_q     <= '0;
            addr_q    <= '0;
            daddr_q   <= '0;
            di_q      <= '0;
            busy_q    <= 1'b0;
            mrst_q    <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            cfg_q     <= cfg_d;
            ent_q     <= ent_d;
            addr_q    <= addr_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
            busy_q    <= busy_d;
            mrst_q    <= mrst_d;
            err_q     <= err_d;
            done_q    <= done_d;
            lock_s1_q <= locked;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rom_addr = addr_q;
    assign daddr    = daddr_q;
    assign di       = di_q;
    assign den      = (state_q == READ) || (state_q == WRITE);
    assign dwe      = (state_q == WRITE);
    assign mmcm_rst = mrst_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Bench for mmcm_drp_reconfig: ROM + DRP slave models, a schedule-based
// reference model with a per-cycle compare process, and directed runs.
module tb_mmcm_drp_reconfig;

    localparam int NR  = 2;
    localparam int NC  = 2;
    localparam int H   = 4;
    localparam int DT  = 255;
    localparam int LT  = 300;
    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [0:0]  cfg_sel;
    logic        busy, done, err;
    logic [1:0]  rom_addr;
    logic [38:0] rom_data;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic        den, dwe;
    logic [15:0] do_m;
    logic        drdy, drdy_m, drdy_x;
    logic        mmcm_rst;
    logic        locked;

    mmcm_drp_reconfig #(
        .N_REGS(NR), .N_CFG(NC), .CFG_W(1), .RST_HOLD(H),
        .DRP_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk12(clk), .rst(rst), .start(start), .cfg_sel(cfg_sel),
        .busy(busy), .done(done), .err(err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .daddr(daddr), .di(di), .den(den), .dwe(dwe),
        .drp_do(do_m), .drdy(drdy),
        .mmcm_rst(mmcm_rst), .locked(locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM and DRP slave models
    logic [38:0] rom [4];
    logic [15:0] mem [128];
    logic [15:0] ref_mem [128];
    logic [15:0] ref_save [128];
    bit          mute_wr;

    initial begin
        rom[0] = {7'h08, 16'h1000, 16'h0145};
        rom[1] = {7'h10, 16'hFF00, 16'h00AB};
        rom[2] = {7'h21, 16'h0000, 16'hBEEF};
        rom[3] = {7'h35, 16'hF0F0, 16'h1234};
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 16'hFFFF;
            ref_mem[i] = 16'hFFFF;
        end
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(posedge clk) begin
        drdy_m <= 1'b0;
        if (den && !(dwe && mute_wr)) begin
            drdy_m <= 1'b1;
            if (dwe) mem[daddr] <= di;
            else     do_m <= mem[daddr];
        end
    end
    assign drdy = drdy_m | drdy_x;

    // reference model: expected event schedule
    typedef struct { int cyc; bit we; logic [6:0] a; logic [15:0] d; } acc_t;
    typedef struct { int cyc; logic [1:0] ra; } fet_t;
    acc_t aq [$];
    fet_t fq [$];
    int   t0, t_rel, t_done, t_err;
    bit   err_prev, model_on, eden;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("busy", 32'(busy), 32'(cyc > t0 && cyc < t_done));
            chk("mmcm_rst", 32'(mmcm_rst), 32'(cyc > t0 && cyc < t_rel));
            chk("done", 32'(done), 32'(cyc == t_done));
            chk("err", 32'(err),
                32'((cyc <= t0) ? err_prev : (cyc >= t_err)));
            while (aq.size() > 0 && aq[0].cyc < cyc) void'(aq.pop_front());
            eden = aq.size() > 0 && aq[0].cyc == cyc;
            chk("den", 32'(den), 32'(eden));
            chk("dwe", 32'(dwe), 32'(eden && aq[0].we));
            if (eden) begin
                chk("daddr", 32'(daddr), 32'(aq[0].a));
                if (aq[0].we) chk("di", 32'(di), 32'(aq[0].d));
                void'(aq.pop_front());
            end
            while (fq.size() > 0 && fq[0].cyc < cyc) void'(fq.pop_front());
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
                chk("rom_addr", 32'(rom_addr), 32'(fq[0].ra));
                void'(fq.pop_front());
            end
        end
    end

    // observations used by the literal checks
    logic [15:0] wr_obs [$];
    logic [6:0]  rd_addr [$];
    logic [1:0]  rd_ra [$];
    int          den_obs [$];
    int          fall_cyc, done_cyc;
    logic        mr_d = 1'b0;

    always @(negedge clk) begin
        mr_d <= mmcm_rst;
        if (mr_d && !mmcm_rst) fall_cyc <= cyc;
        if (done) done_cyc <= cyc;
        if (den && dwe) wr_obs.push_back(di);
        if (den && !dwe) begin
            rd_addr.push_back(daddr);
            rd_ra.push_back(rom_addr);
        end
        if (den) den_obs.push_back(cyc);
    end

    task automatic obs_clear();
        wr_obs.delete();
        rd_addr.delete();
        rd_ra.delete();
        den_obs.delete();
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(input int cfg, input bit drp_tmo,
                          input bit lock_tmo);
        int          base, n;
        logic [38:0] e;
        logic [15:0] rd, wv;
        err_prev = (cyc <= t0) ? err_prev : (cyc >= t_err);
        start   = 1'b1;
        cfg_sel = cfg[0];
        t0      = cyc;
        base    = t0 + 1 + H;
        n       = drp_tmo ? 1 : NR;
        for (int k = 0; k < n; k++) begin
            e = rom[cfg * NR + k];
            fq.push_back('{base + 6 * k, 2'(cfg * NR + k)});
            aq.push_back('{base + 6 * k + 2, 1'b0, e[38:32], 16'h0});
            rd = ref_mem[e[38:32]];
            wv = (rd & e[31:16]) | (e[15:0] & ~e[31:16]);
            aq.push_back('{base + 6 * k + 4, 1'b1, e[38:32], wv});
            if (!drp_tmo) ref_mem[e[38:32]] = wv;
        end
        t_rel  = drp_tmo ? base + 4 + 1 + DT : base + 6 * NR;
        t_err  = drp_tmo ? t_rel : BIG;
        t_done = BIG;
        if (lock_tmo) begin
            t_done = t_rel + 1 + LT;
            t_err  = t_done;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic raise_lock();
        locked = 1'b1;
        t_done = (t_rel + 2 > cyc + 3) ? t_rel + 2 : cyc + 3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int s, lk;

    initial begin
        rst = 1'b1; start = 1'b0; cfg_sel = '0; locked = 1'b0;
        drdy_x = 1'b0; mute_wr = 1'b0; model_on = 1'b0;
        t0 = -1000; t_rel = -1000; t_done = -1000; t_err = BIG;
        err_prev = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        chk("rst den", 32'(den), 0);
        chk("rst dwe", 32'(dwe), 0);
        chk("rst mmcm_rst", 32'(mmcm_rst), 0);
        chk("rst daddr", 32'(daddr), 0);
        chk("rst di", 32'(di), 0);
        chk("rst rom_addr", 32'(rom_addr), 0);
        rst = 1'b0;
        model_on = 1'b1;
        wait_cyc(cyc + 3);

        // nominal, cfg 0
        obs_clear();
        s = cyc;
        launch(0, 1'b0, 1'b0);
        wait_cyc(t_rel + 10);
        lk = cyc;
        raise_lock();
        wait_cyc(t_done + 2);
        chk("nom rd addr", 32'(rd_addr[0]), 32'h08);
        chk("nom di0", 32'(wr_obs[0]), 32'h1145);
        chk("nom di1", 32'(wr_obs[1]), 32'hFFAB);
        chk("nom release", 32'(fall_cyc - s), 17);
        chk("nom lock2done", 32'(done_cyc - lk), 3);
        chk("nom err", 32'(err), 0);
        locked = 1'b0;
        wait_cyc(cyc + 4);

        // config select, cfg_sel changes mid-sequence
        obs_clear();
        launch(1, 1'b0, 1'b0);
        wait_cyc(t0 + 3);
        cfg_sel = 1'b0;
        wait_cyc(t_rel + 5);
        raise_lock();
        wait_cyc(t_done + 2);
        chk("cfg ra0", 32'(rd_ra[0]), 2);
        chk("cfg ra1", 32'(rd_ra[1]), 3);
        chk("cfg di1", 32'(wr_obs[1]), 32'hF2F4);
        locked = 1'b0;
        wait_cyc(cyc + 4);

        // DRP timeout on the first write
        obs_clear();
        mute_wr = 1'b1;
        s = cyc;
        launch(0, 1'b1, 1'b0);
        wait_cyc(t_rel + 3);
        mute_wr = 1'b0;
        raise_lock();
        wait_cyc(t_done + 2);
        chk("tmo release", 32'(fall_cyc - s), 265);
        chk("tmo den count", 32'(den_obs.size()), 2);
        chk("tmo err", 32'(err), 1);
        locked = 1'b0;
        wait_cyc(cyc + 4);

        // lock timeout
        obs_clear();
        launch(0, 1'b0, 1'b1);
        wait_cyc(t_done + 2);
        chk("lock tmo span", 32'(done_cyc - fall_cyc), LT + 1);
        chk("lock tmo err", 32'(err), 1);

        // protocol abuse with stale lock; also clears err
        locked = 1'b1;
        wait_cyc(cyc + 4);
        obs_clear();
        launch(1, 1'b0, 1'b0);
        t_done = t_rel + 2;
        wait_cyc(t0 + 3);
        start = 1'b1;
        wait_cyc(t0 + 4);
        start = 1'b0;
        wait_cyc(t0 + 9);
        start = 1'b1;
        wait_cyc(t0 + 10);
        start = 1'b0;
        wait_cyc(t0 + 11);
        drdy_x = 1'b1;
        wait_cyc(t0 + 12);
        drdy_x = 1'b0;
        wait_cyc(t0 + 18);
        start = 1'b1;
        wait_cyc(t0 + 19);
        start = 1'b0;
        wait_cyc(t_done + 3);
        chk("abuse den count", 32'(den_obs.size()), 4);
        chk("abuse stale lock", 32'(done_cyc - fall_cyc), 2);
        chk("abuse err cleared", 32'(err), 0);
        chk("abuse idle busy", 32'(busy), 0);
        locked = 1'b0;
        wait_cyc(cyc + 4);

        // async reset in WAIT_RD of entry 0
        ref_save = ref_mem;
        launch(0, 1'b0, 1'b0);
        wait_cyc(t0 + 8);
        model_on = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst busy", 32'(busy), 0);
        chk("arst mmcm_rst", 32'(mmcm_rst), 0);
        chk("arst den", 32'(den), 0);
        chk("arst dwe", 32'(dwe), 0);
        chk("arst daddr", 32'(daddr), 0);
        chk("arst di", 32'(di), 0);
        chk("arst rom_addr", 32'(rom_addr), 0);
        chk("arst done", 32'(done), 0);
        chk("arst err", 32'(err), 0);
        wait_cyc(cyc + 3);
        rst = 1'b0;
        aq.delete();
        fq.delete();
        t0 = -1000; t_rel = -1000; t_done = -1000; t_err = BIG;
        err_prev = 1'b0;
        ref_mem = ref_save;
        model_on = 1'b1;
        wait_cyc(cyc + 3);

        // full sequence after reset
        obs_clear();
        launch(0, 1'b0, 1'b0);
        wait_cyc(t_rel + 4);
        raise_lock();
        wait_cyc(t_done + 2);
        chk("post-rst writes", 32'(wr_obs.size()), 2);
        chk("post-rst err", 32'(err), 0);
        locked = 1'b0;
        wait_cyc(cyc + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_reconfig.md
# mmcm_drp_reconfig

Dynamic-reconfiguration master for the clock generator's MMCM DRP port, clocked by the 12 MHz board oscillator that also drives the MMCM's DCLK. On request it holds the MMCM in reset and walks a table of DRP register entries for the selected configuration. For each entry it performs a read-modify-write, then releases reset and waits for lock. This lets the video pixel/serializer clocks switch between modes at run time without a new bitstream.

## Interface
Parameters:
- N_REGS, 23: DRP entries per configuration.
- N_CFG, 2: number of configurations in the table.
- CFG_W, 1: width of cfg_sel (clog2 of N_CFG, min 1).
- RST_HOLD, 4: cycles mmcm_rst is held before the first DRP access.
- DRP_TIMEOUT, 255: max cycles waiting for drdy per access.
- LOCK_TIMEOUT, 65535: max cycles waiting for locked after release.

Ports:
- clk12  in  1  sole clock; also DCLK of the MMCM.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  reconfiguration request; sampled only in IDLE.
- cfg_sel  in  CFG_W  configuration index; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of sequence.
- err  out  1  sticky error flag; cleared on next accepted start.
- rom_addr  out  clog2(N_CFG*N_REGS)  table address = cfg*N_REGS + idx.
- rom_data  in  39  {daddr[38:32], mask[31:16], data[15:0]}; valid one cycle after rom_addr.
- daddr  out  7  DRP address.
- di  out  16  DRP write data.
- den  out  1  DRP enable, one-cycle pulse.
- dwe  out  1  DRP write enable, only together with den.
- do  in  16  DRP read data, valid with drdy.
- drdy  in  1  DRP access complete.
- mmcm_rst  out  1  MMCM RST.
- locked  in  1  MMCM LOCKED; asynchronous, so it is double-flopped internally.

## Operation
- Reset values: busy=0, done=0, err=0, den=0, dwe=0, mmcm_rst=0, daddr=0, di=0, rom_addr=0, state=IDLE, idx=0. The MMCM keeps running its bitstream configuration after reset.
- IDLE: start=1 latches cfg_sel, clears err and sets busy=1, mmcm_rst=1, idx=0, then goes to HOLD. start while busy is ignored and not queued.
- HOLD: counts RST_HOLD cycles, then goes to FETCH.
- FETCH: drives rom_addr, then goes to LATCH.
- LATCH: registers rom_data, then goes to READ.
- READ: den=1, dwe=0, daddr=entry addr for one cycle, then goes to WAIT_RD.
- WAIT_RD: on drdy, captures do and goes to WRITE.
- WRITE: den=1, dwe=1, same daddr, di = (do_captured & mask) | (data & ~mask) for one cycle. A mask bit of 1 preserves that bit. Then goes to WAIT_WR.
- WAIT_WR: on drdy, if idx==N_REGS-1 goes to RELEASE; otherwise idx++ and goes to FETCH.
- DRP timeout: a counter reloads on entry to WAIT_RD or WAIT_WR. If DRP_TIMEOUT cycles pass without drdy, set err=1, abandon the remaining entries and go to RELEASE.
- RELEASE: mmcm_rst=0 for one cycle, then goes to WAIT_LOCK.
- WAIT_LOCK: synchronized locked=1 gives done=1 and a return to IDLE with busy=0. After LOCK_TIMEOUT cycles, set err=1, pulse done and return to IDLE.
- drdy outside WAIT_RD/WAIT_WR is ignored.
- drdy in the same cycle as the timeout expiry counts as success.
- Asynchronous rst mid-sequence forces the reset values immediately. Because mmcm_rst drops to 0, the MMCM restarts with whatever partial DRP contents it holds; the system must issue a new start.

## Timing
- With drdy one cycle after den, each entry takes 6 cycles: FETCH, LATCH, READ, WAIT_RD, WRITE, WAIT_WR.
- Start-to-RELEASE is 1 + RST_HOLD + 6·N_REGS cycles.
- mmcm_rst rises the cycle after start is sampled. It falls on RELEASE entry.
- done rises 2–3 cycles after locked rises (synchronizer plus register). done and busy=0 occur in the same cycle.
- den is never high on two consecutive cycles. At most one DRP access is outstanding.

## Test plan
- Nominal: N_REGS=2, table entry0 {0x08, 0x1000, 0x0145}, DRP model returns do=0xFFFF after 1 cycle, start with cfg_sel=0 -> reads 0x08 then writes di=0x1145. busy is held for 1+4+12 cycles before RELEASE. With locked raised 10 cycles later, done pulses once with err=0.
- Config select: cfg_sel=1 -> rom_addr sequence is 2, 3. The latched cfg is used even if cfg_sel changes mid-sequence.
- DRP timeout: drdy never returns on the first write -> err=1 after 255 cycles, mmcm_rst drops, no further den. After locked, done pulses with err still 1.
- Lock timeout: locked held 0 -> done pulses and err=1 exactly LOCK_TIMEOUT cycles into WAIT_LOCK. A second start clears err.
- Protocol abuse: start pulses while busy, stray drdy in FETCH, and locked=1 throughout reset -> extra starts ignored and no extra den. Because the RMW ran on stale lock, the checker verifies done only after RELEASE.
- Async reset mid-WAIT_RD -> all outputs return to reset values in the same cycle. A new start then runs a full sequence.
